// File: rtl/fir_filter_param.sv
// fir_filter_param: parameterised direct-form FIR filter with run-time
// programmable coefficients and a two-stage pipeline (multiply, then sum).
//
// Build option: define FIR_SAT_EN to saturate out_data to all ones when the
// full-precision sum exceeds 2^OUT_W-1. Without it, out_data wraps to the
// low OUT_W bits of the sum. ovf behaves the same in both builds.
//
// Parameters:
//   TAPS   - number of taps (2..64)
//   DATA_W - unsigned sample width
//   COEF_W - unsigned coefficient width
//   OUT_W  - output width
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - sample strobe, one sample accepted per edge when high
//   in_data    - unsigned input sample
//   coef_we    - coefficient write enable
//   coef_addr  - coefficient index (values >= TAPS are ignored)
//   coef_data  - coefficient value
//   out_valid  - single-cycle result strobe, two edges after acceptance
//   out_data   - filter result (wrapped or saturated)
//   ovf        - full-precision sum exceeded 2^OUT_W-1
//   out_primed - delay line holds TAPS accepted samples
module fir_filter_param #(
    parameter int unsigned TAPS   = 10,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned COEF_W = 4,
    parameter int unsigned OUT_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     ovf,
    output logic                     out_primed
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned ACC_W = PW + AW;
    localparam int unsigned FW    = $clog2(TAPS + 1);

    logic [DATA_W-1:0] x_q [TAPS];
    logic [DATA_W-1:0] x_d [TAPS];
    logic [COEF_W-1:0] c_q [TAPS];
    logic [COEF_W-1:0] c_d [TAPS];
    logic [PW-1:0]     p_q [TAPS];
    logic [PW-1:0]     p_d [TAPS];
    logic [ACC_W-1:0]  s_q;
    logic [ACC_W-1:0]  s_d;
    logic [FW-1:0]     fill_q;
    logic [FW-1:0]     fill_d;
    logic              primed_q;
    logic              primed_d;
    logic              acc_v_q;     // sample accepted at previous edge
    logic              p_v_q;       // products valid, sum due next edge
    logic              out_valid_q;

    // Delay line, coefficient bank and fill counter next state
    always_comb begin
        x_d    = x_q;
        c_d    = c_q;
        fill_d = fill_q;
        if (coef_we && (32'(coef_addr) < TAPS)) begin
            c_d[coef_addr] = coef_data;
        end
        if (in_valid) begin
            x_d[0] = in_data;
            for (int k = 1; k < int'(TAPS); k++) begin
                x_d[k] = x_q[k-1];
            end
            if (fill_q != FW'(TAPS)) begin
                fill_d = fill_q + FW'(1);
            end
        end
        primed_d = (fill_d == FW'(TAPS));
    end

    // Stage 1 products use the delay line and coefficients as updated at
    // the acceptance edge, so a same-edge coefficient write applies.
    always_comb begin
        for (int k = 0; k < int'(TAPS); k++) begin
            p_d[k] = PW'(c_q[k]) * PW'(x_q[k]);
        end
    end

    // Stage 2 full-precision adder tree
    always_comb begin
        s_d = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            s_d = s_d + ACC_W'(p_q[k]);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '{default: '0};
            c_q         <= '{default: '0};
            p_q         <= '{default: '0};
            s_q         <= '0;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            acc_v_q     <= 1'b0;
            p_v_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            c_q         <= c_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
            acc_v_q     <= in_valid;
            p_v_q       <= acc_v_q;
            out_valid_q <= p_v_q;
            if (acc_v_q) begin
                p_q <= p_d;
            end
            if (p_v_q) begin
                s_q <= s_d;
            end
        end
    end

    // Output decode of the stage-2 register; s_q only changes with
    // out_valid, so out_data and ovf hold between results.
    logic [OUT_W-1:0] s_wrap;
    logic             s_ovf;

    if (ACC_W > OUT_W) begin : g_wide
        assign s_ovf  = |s_q[ACC_W-1:OUT_W];
        assign s_wrap = s_q[OUT_W-1:0];
    end else begin : g_narrow
        assign s_ovf  = 1'b0;
        assign s_wrap = OUT_W'(s_q);
    end

`ifdef FIR_SAT_EN
    assign out_data = s_ovf ? '1 : s_wrap;
`else
    assign out_data = s_wrap;
`endif

    assign ovf        = s_ovf;
    assign out_valid  = out_valid_q;
    assign out_primed = primed_q;

endmodule
